ps2_scan_receiver: RTL



---
 rtl/ps2_scan_receiver.sv | 115 +++++++++++
 1 files changed

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: deframes PS/2 keyboard bytes and tracks the held key's make code; optional odd parity via `define PS2_PARITY_CHECK_EN; ports clk, reset, ps2_clk, ps2_data -> data (held make code, 0 when none), code (last byte), code_valid, frame_err
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q;
  state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d, code_q, code_d;
  logic par_q, par_d, brk_q, brk_d, valid_q, valid_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic fall, sample, par_ok, good;
  always_comb begin
    fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    sample = dat_sync_q[SYNC_STAGES-1];
`ifdef PS2_PARITY_CHECK_EN
    par_ok = ^{shift_q, par_q};
`else
    par_ok = 1'b1;
`endif
    state_d = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    par_d = par_q;
    brk_d = brk_q;
    data_d = data_q;
    code_d = code_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    good = 1'b0;
    tmo_d = (fall || state_q == IDLE) ? '0 :
            (tmo_q == TW'(TIMEOUT_CYCLES)) ? tmo_q : tmo_q + TW'(1);
    if (fall) begin
      case (state_q)
        IDLE: if (!sample) begin
          state_d = DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          shift_d = {sample, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d = (bit_cnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_d = sample;
          state_d = STOP;
        end
        default: begin
          good = sample & par_ok;
          valid_d = good;
          err_d = ~good;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE && tmo_d == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      err_d = 1'b1;
    end
    if (good) begin
      code_d = shift_q;
      if (shift_q == 8'hF0) brk_d = 1'b1;
      else if (shift_q != 8'hE0) begin
        data_d = brk_q ? ((shift_q == data_q) ? 8'h00 : data_q) : shift_q;
        brk_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      brk_q <= 1'b0;
      data_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      par_q <= par_d;
      brk_q <= brk_d;
      data_q <= data_d;
      code_q <= code_d;
      valid_q <= valid_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  end
  assign data = data_q;
  assign code = code_q;
  assign code_valid = valid_q;
  assign frame_err = err_q;
endmodule
